// File: rtl/lector_destinos.sv
`default_nettype none
// ============================================================================
// Module   : lector_destinos
// Purpose  : Drains destination FIFOs D0 and D1 with weighted round-robin
//            arbitration and merges the popped words into one registered,
//            source-tagged output stream. Keeps per-destination pop counters
//            and stops reading for good once either FIFO reports an error.
// Ports    : clk, reset_L                - clock, async active-low reset
//            enable                      - reading allowed when high
//            D0_empty/D1_empty           - FIFO empty flags
//            D0_error_output/D1_...      - FIFO error flags
//            D0_data_out/D1_data_out     - FIFO read data (cycle after rd)
//            D0_rd/D1_rd                 - combinational pop requests
//            data_out/valid_out/src_out  - merged registered output stream
//            cnt_D0/cnt_D1               - wrapping pop counters
//            idle_out/active_out/error_out - one-hot state flags
// Revision : 1.0 - initial release
// ============================================================================
module lector_destinos #(
   parameter int BW      = 6,
   parameter int PESO_D0 = 3,
   parameter int PESO_D1 = 1
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          enable,
   input  logic          D0_empty,
   input  logic          D1_empty,
   input  logic          D0_error_output,
   input  logic          D1_error_output,
   input  logic [BW-1:0] D0_data_out,
   input  logic [BW-1:0] D1_data_out,
   output logic          D0_rd,
   output logic          D1_rd,
   output logic [BW-1:0] data_out,
   output logic          valid_out,
   output logic          src_out,
   output logic [7:0]    cnt_D0,
   output logic [7:0]    cnt_D1,
   output logic          idle_out,
   output logic          active_out,
   output logic          error_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      ERROR  = 2'd2
   } state_t;

   state_t       state;
   logic         cur;        // source currently holding the grant
   logic [3:0]   burst;      // consecutive pops already granted to cur
   logic         pend;       // a pop was issued last cycle; its data is on the bus now
   logic         pend_src;

   logic         any_err;
   logic         pop_ok;
   logic         cur_empty;
   logic         sel;
   logic         sel_empty;
   logic         pop;
   logic [3:0]   burst_base;
   logic [4:0]   burst_inc;
   logic [4:0]   weight;

   // Pop decision is combinational so that an empty flag raised at the
   // popping edge suppresses the very next request (no underflow).
   always_comb begin
      any_err    = D0_error_output | D1_error_output;
      pop_ok     = (state == ACTIVE) && enable && !any_err;
      cur_empty  = cur ? D1_empty : D0_empty;
      sel        = cur_empty ? ~cur : cur;
      sel_empty  = sel ? D1_empty : D0_empty;
      pop        = pop_ok && !sel_empty;
      D0_rd      = pop && !sel;
      D1_rd      = pop && sel;
      // A pop from the non-owner starts a fresh burst for that source.
      burst_base = (sel == cur) ? burst : 4'd0;
      burst_inc  = {1'b0, burst_base} + 5'd1;
      weight     = sel ? 5'(PESO_D1) : 5'(PESO_D0);
   end

   // Control FSM; errors override everything and are sticky until reset.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state <= IDLE;
      end else if (any_err) begin
         state <= ERROR;
      end else begin
         case (state)
            IDLE:    if (enable && !(D0_empty && D1_empty)) state <= ACTIVE;
            ACTIVE:  if (!enable || (D0_empty && D1_empty)) state <= IDLE;
            ERROR:   state <= ERROR;
            default: state <= IDLE;
         endcase
      end
   end

   assign idle_out   = (state == IDLE);
   assign active_out = (state == ACTIVE);
   assign error_out  = (state == ERROR);

   // Arbiter, counters and output capture. The capture path is driven only
   // by pend, so a pop issued just before an error or disable still lands.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cur       <= 1'b0;
         burst     <= 4'd0;
         cnt_D0    <= 8'd0;
         cnt_D1    <= 8'd0;
         pend      <= 1'b0;
         pend_src  <= 1'b0;
         data_out  <= '0;
         valid_out <= 1'b0;
         src_out   <= 1'b0;
      end else begin
         if (pop) begin
            if (sel) cnt_D1 <= cnt_D1 + 8'd1;
            else     cnt_D0 <= cnt_D0 + 8'd1;
            if (burst_inc >= weight) begin
               cur   <= ~sel;
               burst <= 4'd0;
            end else begin
               cur   <= sel;
               burst <= burst_inc[3:0];
            end
         end
         pend      <= pop;
         pend_src  <= sel;
         valid_out <= pend;
         if (pend) begin
            data_out <= pend_src ? D1_data_out : D0_data_out;
            src_out  <= pend_src;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lector_destinos.sv
`default_nettype none
// ============================================================================
// Module   : tb_lector_destinos
// Purpose  : Self-checking bench for lector_destinos. FIFO models feed the
//            DUT; a reference model predicts every pop and pushes the
//            expected word into a scoreboard drained by a separate monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lector_destinos;

   localparam int BW = 6;
   localparam int P0 = 3;
   localparam int P1 = 1;

   logic          clk = 1'b0;
   logic          reset_L;
   logic          enable;
   logic          D0_empty, D1_empty;
   logic          D0_error_output, D1_error_output;
   logic [BW-1:0] D0_data_out, D1_data_out;
   logic          D0_rd, D1_rd;
   logic [BW-1:0] data_out;
   logic          valid_out, src_out;
   logic [7:0]    cnt_D0, cnt_D1;
   logic          idle_out, active_out, error_out;

   lector_destinos #(.BW(BW), .PESO_D0(P0), .PESO_D1(P1)) dut (
      .clk(clk), .reset_L(reset_L), .enable(enable),
      .D0_empty(D0_empty), .D1_empty(D1_empty),
      .D0_error_output(D0_error_output), .D1_error_output(D1_error_output),
      .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
      .D0_rd(D0_rd), .D1_rd(D1_rd),
      .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
      .cnt_D0(cnt_D0), .cnt_D1(cnt_D1),
      .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0] d;
      logic          s;
      int            due;
   } item_t;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc   = 0;
   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];
   item_t         sb[$];

   // Reference model: 0 = idle, 1 = active, 2 = error
   int  m_state, m_run, m_cnt0, m_cnt1;
   bit  m_own;
   bit  exp_pop, exp_src;
   bit  lat_rd0, lat_rd1;
   bit  rst_next;

   task automatic check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int weight_of(bit s);
      return s ? P1 : P0;
   endfunction

   task automatic model_clear();
      m_state = 0; m_own = 0; m_run = 0; m_cnt0 = 0; m_cnt1 = 0;
   endtask

   // One clock cycle: check at negedge, advance FIFOs/model at posedge,
   // then apply the next cycle's inputs 1 time unit after the edge.
   task automatic tick(bit en, bit e0, bit e1, int n0, int n1);
      bit            a0, a1, pop0, pop1;
      logic [BW-1:0] w0, w1, v;
      item_t         it;
      @(negedge clk);
      a0 = (q0.size() > 0);
      a1 = (q1.size() > 0);
      exp_pop = 0;
      exp_src = 0;
      if (reset_L && m_state == 1 && enable && !D0_error_output && !D1_error_output && (a0 || a1)) begin
         exp_pop = 1;
         // The owner keeps the grant if it has data, otherwise the other one reads.
         exp_src = (m_own ? a1 : a0) ? m_own : !m_own;
      end
      check("rd0", D0_rd, int'(exp_pop && !exp_src));
      check("rd1", D1_rd, int'(exp_pop && exp_src));
      check("state_flags", {idle_out, active_out, error_out},
            (m_state == 0) ? 4 : (m_state == 1) ? 2 : 1);
      lat_rd0 = D0_rd;
      lat_rd1 = D1_rd;
      @(posedge clk);
      cyc++;
      if (reset_L) begin
         if (exp_pop) begin
            it.d   = exp_src ? q1[0] : q0[0];
            it.s   = exp_src;
            it.due = cyc + 1;
            sb.push_back(it);
            if (exp_src) m_cnt1 = (m_cnt1 + 1) % 256;
            else         m_cnt0 = (m_cnt0 + 1) % 256;
            if (exp_src != m_own) m_run = 0;
            m_run++;
            if (m_run >= weight_of(exp_src)) begin
               m_own = !exp_src;
               m_run = 0;
            end else begin
               m_own = exp_src;
            end
         end
         if (D0_error_output || D1_error_output) m_state = 2;
         else if (m_state == 0 && enable && (a0 || a1)) m_state = 1;
         else if (m_state == 1 && (!enable || (!a0 && !a1))) m_state = 0;
      end
      pop0 = lat_rd0 && (q0.size() > 0);
      pop1 = lat_rd1 && (q1.size() > 0);
      w0 = '0;
      w1 = '0;
      if (pop0) w0 = q0.pop_front();
      if (pop1) w1 = q1.pop_front();
      for (int i = 0; i < n0; i++) begin v = BW'($urandom); q0.push_back(v); end
      for (int i = 0; i < n1; i++) begin v = BW'($urandom); q1.push_back(v); end
      #1;
      if (pop0) D0_data_out = w0;
      if (pop1) D1_data_out = w1;
      enable          = en;
      D0_error_output = e0;
      D1_error_output = e1;
      if (reset_L && !rst_next) begin
         // Reset discards anything in flight, including the FIFO contents.
         sb.delete();
         q0.delete();
         q1.delete();
         model_clear();
      end
      reset_L  = rst_next;
      D0_empty = (q0.size() == 0);
      D1_empty = (q1.size() == 0);
   endtask

   task automatic do_reset();
      rst_next = 0;
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
      rst_next = 1;
      tick(0, 0, 0, 0, 0);
   endtask

   task automatic drain(int limit);
      int k = 0;
      while ((q0.size() + q1.size() + sb.size()) > 0 && k < limit) begin
         tick(1, 0, 0, 0, 0);
         k++;
      end
      check("drain_left", q0.size() + q1.size() + sb.size(), 0);
   endtask

   task automatic check_cnts(string tag);
      check({tag, "_cnt0"}, cnt_D0, m_cnt0);
      check({tag, "_cnt1"}, cnt_D1, m_cnt1);
   endtask

   // Monitor: every valid_out word must match the oldest expected one and
   // arrive exactly two cycles after its pop.
   initial begin
      item_t it;
      forever begin
         @(negedge clk);
         if (reset_L === 1'b1 && valid_out === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", valid_out, 0);
            end else begin
               it = sb.pop_front();
               check("data", data_out, it.d);
               check("src", src_out, it.s);
               check("latency", cyc, it.due);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_L = 0; rst_next = 0; enable = 0;
      D0_empty = 1; D1_empty = 1;
      D0_error_output = 0; D1_error_output = 0;
      D0_data_out = '0; D1_data_out = '0;
      model_clear();

      repeat (3) tick(0, 0, 0, 0, 0);
      check("rst_data", data_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_src", src_out, 0);
      check_cnts("rst");
      check("rst_idle", idle_out, 1);
      rst_next = 1;
      tick(0, 0, 0, 0, 0);

      // Enable with nothing to read stays idle
      repeat (5) tick(1, 0, 0, 0, 0);
      check("empty_idle", idle_out, 1);

      // 5 + 5 words, weighted interleave
      tick(0, 0, 0, 5, 5);
      drain(60);
      check_cnts("w55");

      // D1 only
      do_reset();
      tick(0, 0, 0, 0, 4);
      drain(40);
      check_cnts("d1only");

      // Error pulse mid-burst, then sticky ERROR
      do_reset();
      tick(0, 0, 0, 10, 10);
      repeat (4) tick(1, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      repeat (4) tick(1, 0, 0, 0, 0);
      check("err_sticky", error_out, 1);
      repeat (5) tick(1, 0, 0, 2, 2);
      check("err_still", error_out, 1);
      check("err_trailing", sb.size(), 0);
      check_cnts("err");

      // 300 words through D0: counter wraps
      do_reset();
      tick(0, 0, 0, 300, 0);
      drain(400);
      check_cnts("wrap");
      check("wrap_44", cnt_D0, 44);

      // Enable gap mid-stream
      do_reset();
      tick(0, 0, 0, 8, 8);
      repeat (3) tick(1, 0, 0, 0, 0);
      repeat (2) tick(0, 0, 0, 0, 0);
      drain(60);
      check_cnts("gap");

      // Reset mid-transfer drops the pending capture
      tick(0, 0, 0, 6, 6);
      repeat (3) tick(1, 0, 0, 0, 0);
      do_reset();
      check_cnts("midrst");

      // Randomized traffic with random enable drops
      repeat (400) tick($urandom_range(0, 7) != 0, 0, 0,
                        ($urandom_range(0, 2) == 0) ? 1 : 0,
                        ($urandom_range(0, 3) == 0) ? 1 : 0);
      drain(300);
      check_cnts("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
